quad_enc_gen: RTL and testbench
===============================

QUAD_ENC_GEN -- requirements
Module: quad_enc_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 16, bit width of the signed move-count command.
REQ-002 SHALL have parameter PER_W, default 16, bit width of the edge-period command in clk cycles.
REQ-003 SHALL have parameter PPR, default 4000, quadrature counts per revolution for the index pulse.
REQ-004 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-005 SHALL have port aclr  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port cmd_valid  input  1  move command present.
REQ-007 SHALL have port cmd_ready  output  1  generator idle and able to accept a command.
REQ-008 SHALL have port cmd_delta  input  CNT_W  signed count of quadrature edges; positive is forward.
REQ-009 SHALL have port cmd_period  input  PER_W  clk cycles between consecutive edges.
REQ-010 SHALL have port abort  input  1  synchronous stop request.
REQ-011 SHALL have ports enc_A, enc_B, enc_Z  output  1 each  registered quadrature and index outputs.
REQ-012 SHALL have port busy  output  1  move in progress.
REQ-013 SHALL have port pos  output  32  signed accumulated edge position.

Function
REQ-014 SHALL implement states IDLE and RUN; cmd_ready = (state == IDLE), busy = (state == RUN).
REQ-015 SHALL accept a command on a cycle with cmd_valid && cmd_ready and latch delta sign, |delta| as an unsigned CNT_W magnitude, and period.
REQ-016 SHALL remain in IDLE with no output change when the accepted delta is 0.
REQ-017 SHALL treat cmd_period = 0 as 1.
REQ-018 SHALL enter RUN on acceptance of a nonzero delta and produce the first edge exactly period cycles after the acceptance edge, with each subsequent edge period cycles after the previous one.
REQ-019 SHALL step the forward sequence {A,B} 00->10->11->01->00 (A leads B) and the reverse sequence as its exact inverse, changing exactly one output per edge.
REQ-020 SHALL update pos by +1 (forward) or -1 (reverse) on the same cycle as each edge, with two's-complement wrap at 32 bits.
REQ-021 SHALL return to IDLE on the cycle the |delta|-th edge is output, so cmd_ready is high the following cycle.
REQ-022 SHALL handle a delta of -2^(CNT_W-1) as exactly 2^(CNT_W-1) reverse edges.
REQ-023 SHALL, when abort is high in RUN, return to IDLE on the next edge without emitting further edges; A/B/Z/pos hold their current values.
REQ-024 SHALL give abort priority over an edge due in the same cycle: the edge is suppressed.
REQ-025 SHALL ignore abort in IDLE, and SHALL give abort priority over acceptance in the same cycle: no command is accepted.
REQ-026 SHALL continue A/B phase and pos across commands; a new command resumes from the current quadrature state.

Reset
REQ-027 SHALL on aclr asynchronously force state IDLE, enc_A=0, enc_B=0, pos=0, period counter 0, remaining count 0.
REQ-028 SHALL abandon any move in progress when aclr asserts mid-move, and accept commands from the first clk edge after release.

Configuration
REQ-029 SHALL, with macro QUAD_ENC_GEN_INDEX_EN defined, keep an index counter 0..PPR-1 that moves with every edge and wraps in both directions (0 -1 -> PPR-1), drives enc_Z = 1 while the counter is 0, and resets the counter to 0 (enc_Z = 1 out of reset).
REQ-030 SHALL, without QUAD_ENC_GEN_INDEX_EN, tie enc_Z to 0 and omit the index counter entirely.

Verification
REQ-031 SHALL cover: delta=+4, period=3 -> A/B 10,11,01,00 at cycles 3,6,9,12 after acceptance; pos=4; cmd_ready high at cycle 13.
REQ-032 SHALL cover: delta=-2, period=1 from AB=00 -> AB 01 then 11 on consecutive cycles; pos=-2.
REQ-033 SHALL cover: delta=+10, period=5, abort at cycle 12 -> exactly 2 edges, pos=2, IDLE next cycle, AB held at 11.
REQ-034 SHALL cover: delta=0, then cmd_period=0 with delta=+3 -> first command gives no edges; second gives edges on 3 consecutive cycles.
REQ-035 SHALL cover: with QUAD_ENC_GEN_INDEX_EN and PPR=8, delta=+8 then -1 -> enc_Z low for edges 1-7, high after edge 8, low after the reverse edge; without the macro enc_Z is constantly 0.
REQ-036 SHALL cover: aclr pulse mid-move (delta=+100, after 5 edges) -> AB=00, pos=0, cmd_ready=1 immediately after release.

Source files
------------

// File: rtl/quad_enc_gen.sv
// Quadrature encoder emulator: emits |delta| A/B edges spaced cmd_period clk cycles apart, tracking signed position.
// Latency: first edge lands cmd_period cycles after the accepting clk edge; A/B/Z/pos are all registered.
// Backpressure: cmd_ready is low for the whole move; abort ends a move on the next clk edge and wins over any due edge.
// Optional index output enabled by defining QUAD_ENC_GEN_INDEX_EN (enc_Z tied low otherwise).
module quad_enc_gen #(
    parameter int CNT_W = 16,
    parameter int PER_W = 16,
    parameter int PPR   = 4000
) (
    input  logic                    clk,
    input  logic                    aclr,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic signed [CNT_W-1:0] cmd_delta,
    input  logic        [PER_W-1:0] cmd_period,
    input  logic                    abort,
    output logic                    enc_A,
    output logic                    enc_B,
    output logic                    enc_Z,
    output logic                    busy,
    output logic signed [31:0]      pos
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic               dir_q, dir_d;       // 1 = reverse
    logic [CNT_W-1:0]   rem_q, rem_d;       // edges still to emit
    logic [PER_W-1:0]   per_q, per_d;       // edge spacing, never 0
    logic [PER_W-1:0]   cnt_q, cnt_d;       // cycles until next edge
    logic               a_q, a_d;
    logic               b_q, b_d;
    logic signed [31:0] pos_q, pos_d;
    logic               edge_now;
    logic [CNT_W-1:0]   delta_u;
    logic [CNT_W-1:0]   mag;
    logic [PER_W-1:0]   per_eff;

    // Command decode, move sequencing and quadrature stepping.
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        rem_d    = rem_q;
        per_d    = per_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        pos_d    = pos_q;
        edge_now = 1'b0;

        // Magnitude as unsigned CNT_W so the most negative delta maps to 2^(CNT_W-1).
        delta_u = cmd_delta;
        mag     = cmd_delta[CNT_W-1] ? (~delta_u + CNT_W'(1)) : delta_u;
        per_eff = (cmd_period == '0) ? PER_W'(1) : cmd_period;

        case (state_q)
            IDLE: begin
                if (cmd_valid && !abort) begin
                    dir_d = cmd_delta[CNT_W-1];
                    rem_d = mag;
                    per_d = per_eff;
                    cnt_d = per_eff;
                    if (mag != '0) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q == PER_W'(1)) begin
                    edge_now = 1'b1;
                    cnt_d    = per_q;
                    rem_d    = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - PER_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Gray step: forward 00->10->11->01, reverse is the mirror image.
        if (edge_now) begin
            if (!dir_q) begin
                if (a_q == b_q) a_d = ~a_q;
                else            b_d = ~b_q;
                pos_d = pos_q + 32'sd1;
            end else begin
                if (a_q == b_q) b_d = ~b_q;
                else            a_d = ~a_q;
                pos_d = pos_q - 32'sd1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            rem_q   <= '0;
            per_q   <= PER_W'(1);
            cnt_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            rem_q   <= rem_d;
            per_q   <= per_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            pos_q   <= pos_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign enc_A     = a_q;
    assign enc_B     = b_q;
    assign pos       = pos_q;

`ifdef QUAD_ENC_GEN_INDEX_EN
    localparam int IDX_W = (PPR > 1) ? $clog2(PPR) : 1;

    logic [IDX_W-1:0] idx_q, idx_d;
    logic             z_q, z_d;

    // Index counter follows every edge modulo PPR; Z marks position 0.
    always_comb begin
        idx_d = idx_q;
        if (edge_now) begin
            if (!dir_q) idx_d = (idx_q == IDX_W'(PPR - 1)) ? '0 : idx_q + IDX_W'(1);
            else        idx_d = (idx_q == '0) ? IDX_W'(PPR - 1) : idx_q - IDX_W'(1);
        end
        z_d = (idx_d == '0);
    end

    // Index registers; Z comes out of reset high because the counter is 0.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            idx_q <= '0;
            z_q   <= 1'b1;
        end else begin
            idx_q <= idx_d;
            z_q   <= z_d;
        end
    end

    assign enc_Z = z_q;
`else
    assign enc_Z = 1'b0;
`endif

endmodule

// File: tb/tb_quad_enc_gen.sv
// Randomized and directed bench for quad_enc_gen against a position-based reference model.
// Model: A/B derive from position mod 4, Z from position mod PPR; edges predicted by cycle arithmetic.
// Runs with or without QUAD_ENC_GEN_INDEX_EN.
module tb_quad_enc_gen;

    localparam int CNT_W = 16;
    localparam int PER_W = 16;
    localparam int PPR_T = 8;

    logic                    clk = 1'b0;
    logic                    aclr = 1'b1;
    logic                    cmd_valid = 1'b0;
    logic                    cmd_ready;
    logic signed [CNT_W-1:0] cmd_delta = '0;
    logic        [PER_W-1:0] cmd_period = '0;
    logic                    abort = 1'b0;
    logic                    enc_A, enc_B, enc_Z, busy;
    logic signed [31:0]      pos;

    int n_vec = 0;
    int n_err = 0;
    int m_pos = 0;

    quad_enc_gen #(.CNT_W(CNT_W), .PER_W(PER_W), .PPR(PPR_T)) dut (
        .clk        (clk),
        .aclr       (aclr),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_delta  (cmd_delta),
        .cmd_period (cmd_period),
        .abort      (abort),
        .enc_A      (enc_A),
        .enc_B      (enc_B),
        .enc_Z      (enc_Z),
        .busy       (busy),
        .pos        (pos)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] ab_of(input int p);
        case (p & 3)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic logic z_of(input int p);
`ifdef QUAD_ENC_GEN_INDEX_EN
        return (((p % PPR_T) + PPR_T) % PPR_T) == 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_state(input string tag, input logic exp_busy);
        check(tag, 64'({busy, cmd_ready, enc_A, enc_B, enc_Z, pos}),
                   64'({exp_busy, ~exp_busy, ab_of(m_pos), z_of(m_pos), m_pos}));
    endtask

    // One command; abort_at = cycle after acceptance when abort is high (0 = never);
    // returns early (move still running) after max_edges edges.
    task automatic run_cmd(input int delta, input int period, input int abort_at, input int max_edges);
        int p, n, dir, k, c;
        bit done;
        p   = (period == 0) ? 1 : period;
        n   = (delta < 0) ? -delta : delta;
        dir = (delta < 0) ? -1 : 1;
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_delta  = delta[CNT_W-1:0];
        cmd_period = period[PER_W-1:0];
        check("ready_before_cmd", 64'(cmd_ready), 64'(1));
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        done = (n == 0);
        k = 0;
        c = 0;
        check_state("accept", ~done);
        while (!done && k < max_edges) begin
            c++;
            abort = (c == abort_at);
            @(posedge clk);
            @(negedge clk);
            if (c == abort_at) begin
                done = 1'b1;
            end else if (c % p == 0) begin
                m_pos += dir;
                k++;
                if (k == n) done = 1'b1;
            end
            check_state("step", ~done);
        end
        abort = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 aclr = 1'b1;
        @(posedge clk);
        #2 aclr = 1'b0;
        m_pos = 0;
    endtask

    initial begin
        int d, per, ab;

        // Reset state.
        #12;
        check_state("reset_held", 1'b0);
        @(posedge clk);
        #2 aclr = 1'b0;
        #1 check_state("reset_rel", 1'b0);

        // +4 edges, period 3, from AB=00.
        run_cmd(4, 3, 0, 1 << 30);
        check("r031_pos", 64'(pos), 64'(4));
        check("r031_ab", 64'({enc_A, enc_B}), 64'(2'b00));

        // -2 edges, period 1, from AB=00.
        do_reset();
        run_cmd(-2, 1, 0, 1 << 30);
        check("r032_pos", 64'(pos), 64'(-2));
        check("r032_ab", 64'({enc_A, enc_B}), 64'(2'b11));

        // +10 edges, period 5, abort at cycle 12.
        do_reset();
        run_cmd(10, 5, 12, 1 << 30);
        check("r033_pos", 64'(pos), 64'(2));
        check("r033_ab", 64'({enc_A, enc_B}), 64'(2'b11));
        check("r033_ready", 64'(cmd_ready), 64'(1));

        // Zero delta, then period 0 treated as 1.
        do_reset();
        run_cmd(0, 7, 0, 1 << 30);
        check("r034_zero_pos", 64'(pos), 64'(0));
        run_cmd(3, 0, 0, 1 << 30);
        check("r034_pos", 64'(pos), 64'(3));

        // Index pulse over one revolution and back.
        do_reset();
        run_cmd(8, 2, 0, 1 << 30);
`ifdef QUAD_ENC_GEN_INDEX_EN
        check("r035_z_rev", 64'(enc_Z), 64'(1));
`else
        check("r035_z_rev", 64'(enc_Z), 64'(0));
`endif
        run_cmd(-1, 1, 0, 1 << 30);
        check("r035_z_back", 64'(enc_Z), 64'(0));

        // Reset mid-move, then a command on the first edge after release.
        run_cmd(100, 2, 0, 5);
        @(posedge clk);
        #2 aclr = 1'b1;
        m_pos = 0;
        #1 check_state("r036_in_reset", 1'b0);
        @(posedge clk);
        #2 aclr = 1'b0;
        #1 check_state("r036_released", 1'b0);
        run_cmd(3, 1, 0, 1 << 30);
        check("r036_pos", 64'(pos), 64'(3));

        // Abort wins over acceptance in IDLE.
        @(negedge clk);
        abort      = 1'b1;
        cmd_valid  = 1'b1;
        cmd_delta  = 16'sd5;
        cmd_period = 16'd1;
        @(posedge clk);
        @(negedge clk);
        abort     = 1'b0;
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_state("abort_idle", 1'b0);
            @(negedge clk);
        end

        // Randomized moves with occasional aborts.
        for (int i = 0; i < 30; i++) begin
            d   = int'($urandom_range(0, 24)) - 12;
            per = int'($urandom_range(0, 4));
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0;
            run_cmd(d, per, ab, 1 << 30);
        end

        // Most negative delta.
        run_cmd(-32768, 1, 0, 1 << 30);
        check("min_delta_ready", 64'(cmd_ready), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
